// File: rtl/matrix_printer_gen.sv
// rtl/matrix_printer_gen.sv - packed matrix to decimal ASCII byte stream for uart_tx
module matrix_printer_gen #(
  parameter int ELEM_WIDTH = 16,
  parameter int MAX_DIM    = 5,
  parameter int DIGITS     = 5,
  parameter int DIM_W      = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DIM_W-1:0]                      dimM,
  input  logic [DIM_W-1:0]                      dimN,
  input  logic [MAX_DIM*MAX_DIM*ELEM_WIDTH-1:0] matrix_flat,
  input  logic                                  is_signed,
  input  logic                                  use_crlf,
  input  logic [3:0]                            pad_width,
  input  logic                                  tx_busy,
  output logic                                  tx_start,
  output logic [7:0]                            tx_data,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int N_EL  = MAX_DIM * MAX_DIM;
  localparam int IDX_W = $clog2(N_EL + 1);
  localparam int BC_W  = $clog2(16 + DIGITS + 3);
  localparam int CNT_W = $clog2(ELEM_WIDTH + 1);
  localparam int BCD_W = DIGITS * 4;

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_LOAD, S_CONV, S_SEND, S_ADV, S_DONE, S_WAIT_LOW
  } state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]      dm_q, dn_q, row_q, col_q;
  logic                  sgn_q, crlf_q, rej_q, neg_q, wait_q;
  logic [3:0]            padw_q;
  logic [IDX_W-1:0]      idx_q;
  logic [ELEM_WIDTH-1:0] sh_q, elem;
  logic [BCD_W-1:0]      bcd_q, bcd_adj;
  logic [CNT_W-1:0]      cnt_q;
  logic [BC_W-1:0]       bc_q, nd, body, pad, digit_end, total, di;
  logic [7:0]            cur_byte;
  logic                  bad_req, last_col, last_row, last_byte, byte_ok;

  always_comb begin
    elem = '0;
    for (int k = 0; k < N_EL; k++)
      if (idx_q == IDX_W'(k)) elem = matrix_flat[k*ELEM_WIDTH +: ELEM_WIDTH];
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  assign bad_req = (dimM == '0) || (dimN == '0) ||
                   (dimM > DIM_W'(MAX_DIM)) || (dimN > DIM_W'(MAX_DIM));
  assign last_col = (col_q == dn_q - DIM_W'(1));
  assign last_row = (row_q == dm_q - DIM_W'(1));

  // Field layout: [pad spaces][-][digits][terminator]
  always_comb begin
    nd = BC_W'(1);
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[i*4 +: 4] != 4'd0) nd = BC_W'(i + 1);
    body      = nd + BC_W'(neg_q);
    pad       = (BC_W'(padw_q) > body) ? BC_W'(padw_q) - body : '0;
    digit_end = pad + body;
    total     = digit_end + ((last_col && crlf_q) ? BC_W'(2) : BC_W'(1));
    di        = digit_end - BC_W'(1) - bc_q;
  end

  always_comb begin
    cur_byte = 8'h0A;
    if (bc_q < pad) begin
      cur_byte = 8'h20;
    end else if (neg_q && bc_q == pad) begin
      cur_byte = 8'h2D;
    end else if (bc_q < digit_end) begin
      for (int i = 0; i < DIGITS; i++)
        if (di == BC_W'(i)) cur_byte = 8'h30 + {4'h0, bcd_q[i*4 +: 4]};
    end else if (!last_col) begin
      cur_byte = 8'h09;
    end else if (crlf_q && bc_q == digit_end) begin
      cur_byte = 8'h0D;
    end
  end

  assign last_byte = (bc_q == total - BC_W'(1));
  assign byte_ok   = wait_q && !tx_busy && !tx_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_LATCH;
      S_LATCH:    state_d = bad_req ? S_DONE : S_LOAD;
      S_LOAD:     state_d = S_CONV;
      S_CONV:     if (cnt_q == CNT_W'(ELEM_WIDTH - 1)) state_d = S_SEND;
      S_SEND:     if (byte_ok && last_byte) state_d = S_ADV;
      S_ADV:      state_d = (last_row && last_col) ? S_DONE : S_LOAD;
      S_DONE:     state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!start) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_q     <= '0;
      dn_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      sgn_q    <= 1'b0;
      crlf_q   <= 1'b0;
      rej_q    <= 1'b0;
      neg_q    <= 1'b0;
      wait_q   <= 1'b0;
      padw_q   <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      bc_q     <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state_q)
        S_LATCH: begin
          dm_q   <= dimM;
          dn_q   <= dimN;
          sgn_q  <= is_signed;
          crlf_q <= use_crlf;
          padw_q <= pad_width;
          rej_q  <= bad_req;
          row_q  <= '0;
          col_q  <= '0;
          idx_q  <= '0;
        end
        S_LOAD: begin
          // Negation in ELEM_WIDTH bits keeps the most negative value exact
          neg_q  <= sgn_q && elem[ELEM_WIDTH-1];
          sh_q   <= (sgn_q && elem[ELEM_WIDTH-1]) ?
                    (~elem) + {{(ELEM_WIDTH-1){1'b0}}, 1'b1} : elem;
          bcd_q  <= '0;
          cnt_q  <= '0;
          bc_q   <= '0;
          wait_q <= 1'b0;
        end
        S_CONV: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], sh_q[ELEM_WIDTH-1]};
          sh_q  <= {sh_q[ELEM_WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_SEND: begin
          if (!wait_q && !tx_busy) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
            wait_q   <= 1'b1;
          end else if (wait_q && tx_busy) begin
            tx_start <= 1'b0;
          end else if (byte_ok) begin
            wait_q <= 1'b0;
            bc_q   <= last_byte ? '0 : bc_q + BC_W'(1);
          end
        end
        S_ADV: begin
          idx_q <= idx_q + IDX_W'(1);
          if (last_col) begin
            col_q <= '0;
            row_q <= row_q + DIM_W'(1);
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = (state_q == S_DONE) && rej_q;

endmodule

// File: tb/tb_matrix_printer_gen.sv
// tb/tb_matrix_printer_gen.sv - directed self-checking bench for matrix_printer_gen
module tb_matrix_printer_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   dimM = '0;
  logic [2:0]   dimN = '0;
  logic [399:0] matrix_flat = '0;
  logic         is_signed = 1'b0;
  logic         use_crlf = 1'b0;
  logic [3:0]   pad_width = '0;
  logic         tx_busy = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int busy_cnt = 0;
  int stall_idx = -1;
  int stall_len = 200;

  int n_done, n_err, done_cyc;
  bit tmo;

  matrix_printer_gen dut (
    .clk(clk), .rst(rst), .start(start), .dimM(dimM), .dimN(dimN),
    .matrix_flat(matrix_flat), .is_signed(is_signed), .use_crlf(use_crlf),
    .pad_width(pad_width), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: accepts a byte, stays busy a few cycles (or stall_len on stall_idx)
  always @(negedge clk) begin
    if (rst) begin
      tx_busy  = 1'b0;
      busy_cnt = 0;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end else if (tx_start) begin
      rx_q.push_back(tx_data);
      tx_busy  = 1'b1;
      busy_cnt = (rx_q.size() - 1 == stall_idx) ? stall_len : 3;
    end
  end

  task automatic set_el(input int k, input logic [15:0] v);
    matrix_flat[k*16 +: 16] = v;
  endtask

  function automatic int diff_idx(input string s);
    if (rx_q.size() != s.len()) return (rx_q.size() < s.len()) ? rx_q.size() : s.len();
    for (int i = 0; i < s.len(); i++)
      if (rx_q[i] !== s[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  task automatic start_print(input logic [2:0] m, input logic [2:0] n, input logic sg,
                             input logic cr, input logic [3:0] pw);
    @(negedge clk);
    rx_q.delete();
    dimM = m; dimN = n; is_signed = sg; use_crlf = cr; pad_width = pw;
    start = 1'b1;
  endtask

  task automatic wait_done();
    n_done = 0; n_err = 0; done_cyc = 0; tmo = 1'b1;
    for (int c = 1; c <= 20000; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (err) n_err++;
        done_cyc = c;
        tmo = 1'b0;
        break;
      end
    end
    // start held high past done must not re-trigger a print
    repeat (20) begin
      @(negedge clk);
      if (done) n_done++;
      if (err) n_err++;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({done, err} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b want 00", {done, err}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_crlf_2x2();
    string exp;
    int d;
    exp = "1\t23\015\n456\t7\015\n";
    matrix_flat = '0;
    set_el(0, 16'd1); set_el(1, 16'd23); set_el(2, 16'd456); set_el(3, 16'd7);
    start_print(3'd2, 3'd2, 1'b0, 1'b1, 4'd0);
    wait_done();
    d = diff_idx(exp);
    checks++; if (tmo) begin errors++; $display("FAIL crlf_timeout: no done within budget"); end
    checks++; if (d != -1) begin errors++; $display("FAIL crlf_bytes: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL crlf_done_count: got %0d want 1", n_done); end
    checks++; if (n_err != 0) begin errors++; $display("FAIL crlf_err: got %0d want 0", n_err); end
  endtask

  task automatic test_signed_unsigned();
    string exp;
    int d;
    matrix_flat = '0;
    set_el(0, 16'hFFFF); set_el(1, 16'h8000); set_el(2, 16'h0000);
    exp = "-1\t-32768\t0\n";
    start_print(3'd1, 3'd3, 1'b1, 1'b0, 4'd0);
    wait_done();
    d = diff_idx(exp);
    checks++; if (d != -1 || tmo) begin errors++; $display("FAIL signed_bytes: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
    exp = "65535\t32768\t0\n";
    start_print(3'd1, 3'd3, 1'b0, 1'b0, 4'd0);
    wait_done();
    d = diff_idx(exp);
    checks++; if (d != -1 || tmo) begin errors++; $display("FAIL unsigned_bytes: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
  endtask

  task automatic test_padding();
    string exp;
    int d;
    matrix_flat = '0;
    set_el(0, 16'd5); set_el(1, 16'hFFF4);
    exp = "   5\t -12\n";
    start_print(3'd1, 3'd2, 1'b1, 1'b0, 4'd4);
    wait_done();
    d = diff_idx(exp);
    checks++; if (d != -1 || tmo) begin errors++; $display("FAIL pad4_bytes: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
    matrix_flat = '0;
    set_el(0, 16'd123);
    exp = "123\n";
    start_print(3'd1, 3'd1, 1'b0, 1'b0, 4'd2);
    wait_done();
    d = diff_idx(exp);
    checks++; if (d != -1 || tmo) begin errors++; $display("FAIL pad_no_trunc: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
  endtask

  task automatic test_reject();
    logic [2:0] ms[3] = '{3'd0, 3'd1, 3'd6};
    logic [2:0] ns[3] = '{3'd2, 3'd6, 3'd1};
    for (int t = 0; t < 3; t++) begin
      start_print(ms[t], ns[t], 1'b0, 1'b0, 4'd0);
      wait_done();
      checks++; if (tmo || done_cyc > 4) begin errors++; $display("FAIL reject_latency[%0d]: got %0d cycles want <=4", t, done_cyc); end
      checks++; if (n_done != 1 || n_err != 1) begin errors++; $display("FAIL reject_pulses[%0d]: done %0d err %0d want 1 1", t, n_done, n_err); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL reject_no_tx[%0d]: got %0d bytes want 0", t, rx_q.size()); end
    end
  endtask

  task automatic test_stall();
    string exp;
    int d, viol;
    bit seen;
    matrix_flat = '0;
    set_el(0, 16'd1); set_el(1, 16'd23);
    exp = "1\t23\n";
    stall_idx = 1;
    start_print(3'd1, 3'd2, 1'b0, 1'b0, 4'd0);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rx_q.size() == 2) begin seen = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    viol = 0;
    repeat (190) begin
      @(negedge clk);
      if (tx_start !== 1'b0 || tx_data !== 8'h09) viol++;
    end
    checks++; if (!seen || viol != 0) begin errors++; $display("FAIL stall_hold: seen %0b violations %0d want 1 0", seen, viol); end
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL stall_no_new_byte: got %0d bytes want 2", rx_q.size()); end
    wait_done();
    stall_idx = -1;
    d = diff_idx(exp);
    checks++; if (d != -1 || tmo) begin errors++; $display("FAIL stall_bytes: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
  endtask

  task automatic test_reset_midrun();
    string exp;
    int d;
    bit seen;
    matrix_flat = '0;
    exp = "";
    for (int k = 0; k < 25; k++) begin
      set_el(k, 16'(k * 1001));
      exp = {exp, $sformatf("%0d", k * 1001), ((k % 5) == 4) ? "\n" : "\t"};
    end
    start_print(3'd5, 3'd5, 1'b0, 1'b0, 4'd0);
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (rx_q.size() == 3) begin seen = 1'b1; break; end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (!seen || tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start: seen %0b got %b want 0", seen, tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_print(3'd5, 3'd5, 1'b0, 1'b0, 4'd0);
    wait_done();
    d = diff_idx(exp);
    checks++; if (d != -1 || tmo) begin errors++; $display("FAIL midrst_reprint: idx %0d got %h want %h (len %0d want %0d)", d, rx_at(d), exp[d], rx_q.size(), exp.len()); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL midrst_done_count: got %0d want 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_crlf_2x2();
    test_signed_unsigned();
    test_padding();
    test_reject();
    test_stall();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
